// File: rtl/player_action_fsm.sv
// Player action sequencer: idle/move/jump/block plus a two-stage attack combo
// and hit-stun, with per-state frame countdown and one-cycle strike/block pulses.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no action; accepts any control
// MOVE     | walking while move_btn held
// JUMP     | airborne for JUMP_LEN cycles, buttons ignored
// BLOCK    | guarding while opponent attacks; absorbs hits
// ATTACK1  | first strike, ATK1_LEN cycles; late presses queue ATTACK2
// ATTACK2  | combo follow-up, ATK2_LEN cycles
// HIT      | stunned for HITSTUN_LEN cycles; further hits restart the stun
// RSVD     | unused encoding, recovers to IDLE
module player_action_fsm #(
   parameter int CNT_W       = 8,
   parameter int ATK1_LEN    = 6,
   parameter int ATK2_LEN    = 8,
   parameter int COMBO_WIN   = 4,
   parameter int HITSTUN_LEN = 10,
   parameter int JUMP_LEN    = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             move_btn,
   input  logic             jump_btn,
   input  logic             attack_btn,
   input  logic             opponent_attack,
   input  logic             hit_in,
   output logic [2:0]       action_state,
   output logic             move_active,
   output logic             jump_active,
   output logic             attack_active,
   output logic             block_active,
   output logic             hit_active,
   output logic             attack_strike,
   output logic             block_success,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_MOVE    = 3'b001,
      ST_JUMP    = 3'b010,
      ST_BLOCK   = 3'b011,
      ST_ATTACK1 = 3'b100,
      ST_ATTACK2 = 3'b101,
      ST_RSVD    = 3'b110,
      ST_HIT     = 3'b111
   } state_t;

   localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_LEN - 1);
   localparam logic [CNT_W-1:0] ATK1_LOAD = CNT_W'(ATK1_LEN - 1);
   localparam logic [CNT_W-1:0] ATK2_LOAD = CNT_W'(ATK2_LEN - 1);
   localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HITSTUN_LEN - 1);
   localparam logic [CNT_W:0]   COMBO_LIM = (CNT_W + 1)'(COMBO_WIN);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             combo_req;
   logic             combo_nxt;
   logic             atk_q;
   logic             atk_edge;
   logic             expired;
   logic             combo_take;
   logic             reload;
   logic             timed;

   assign atk_edge   = attack_btn & ~atk_q;
   assign expired    = (frame_cnt == '0);
   // strict compare so a zero-width window accepts nothing, even at expiry
   assign combo_take = atk_edge && ({1'b0, frame_cnt} < COMBO_LIM);
   assign timed      = (state == ST_JUMP) || (state == ST_ATTACK1) ||
                       (state == ST_ATTACK2) || (state == ST_HIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         frame_cnt <= '0;
         combo_req <= 1'b0;
         atk_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= cnt_nxt;
         combo_req <= combo_nxt;
         atk_q     <= attack_btn;
      end
   end

   always_comb begin
      state_nxt = state;
      reload    = 1'b0;
      combo_nxt = 1'b0;
      cnt_nxt   = '0;
      case (state)
         ST_IDLE: begin
            if (hit_in)               state_nxt = ST_HIT;
            else if (atk_edge)        state_nxt = ST_ATTACK1;
            else if (jump_btn)        state_nxt = ST_JUMP;
            else if (move_btn)        state_nxt = ST_MOVE;
            else if (opponent_attack) state_nxt = ST_BLOCK;
         end
         ST_MOVE: begin
            if (hit_in)               state_nxt = ST_HIT;
            else if (atk_edge)        state_nxt = ST_ATTACK1;
            else if (jump_btn)        state_nxt = ST_JUMP;
            else if (!move_btn)       state_nxt = ST_IDLE;
         end
         ST_JUMP: begin
            if (hit_in)               state_nxt = ST_HIT;
            else if (expired)         state_nxt = ST_IDLE;
         end
         ST_BLOCK: begin
            if (atk_edge)             state_nxt = ST_ATTACK1;
            else if (!opponent_attack) state_nxt = ST_IDLE;
         end
         ST_ATTACK1: begin
            if (hit_in)               state_nxt = ST_HIT;
            else if (expired)         state_nxt = (combo_req || combo_take) ? ST_ATTACK2 : ST_IDLE;
            else                      combo_nxt = combo_req | combo_take;
         end
         ST_ATTACK2: begin
            if (hit_in)               state_nxt = ST_HIT;
            else if (expired)         state_nxt = ST_IDLE;
         end
         ST_HIT: begin
            if (hit_in)               reload    = 1'b1;
            else if (expired)         state_nxt = ST_IDLE;
         end
         default:                     state_nxt = ST_IDLE;
      endcase

      // any state change or stun restart loads the new state's duration
      if ((state_nxt != state) || reload) begin
         case (state_nxt)
            ST_JUMP:    cnt_nxt = JUMP_LOAD;
            ST_ATTACK1: cnt_nxt = ATK1_LOAD;
            ST_ATTACK2: cnt_nxt = ATK2_LOAD;
            ST_HIT:     cnt_nxt = HIT_LOAD;
            default:    cnt_nxt = '0;
         endcase
      end else if (timed) begin
         cnt_nxt = frame_cnt - CNT_W'(1);
      end
   end

   assign action_state  = state;
   assign move_active   = (state == ST_MOVE);
   assign jump_active   = (state == ST_JUMP);
   assign attack_active = (state == ST_ATTACK1) || (state == ST_ATTACK2);
   assign block_active  = (state == ST_BLOCK);
   assign hit_active    = (state == ST_HIT);
   assign attack_strike = ((state == ST_ATTACK1) && (frame_cnt == ATK1_LOAD)) ||
                          ((state == ST_ATTACK2) && (frame_cnt == ATK2_LOAD));
   assign block_success = (state == ST_BLOCK) && hit_in;

endmodule

// File: tb/tb_player_action_fsm.sv
// Bench for player_action_fsm: directed scenarios plus random controls, all
// checked every cycle against an elapsed-time reference model.
module tb_player_action_fsm;

   localparam int CNT_W       = 8;
   localparam int ATK1_LEN    = 6;
   localparam int ATK2_LEN    = 8;
   localparam int COMBO_WIN   = 4;
   localparam int HITSTUN_LEN = 10;
   localparam int JUMP_LEN    = 12;

   localparam int S_IDLE = 0, S_MOVE = 1, S_JUMP = 2, S_BLOCK = 3;
   localparam int S_A1 = 4, S_A2 = 5, S_HIT = 7;

   logic             clk;
   logic             reset;
   logic             move_btn, jump_btn, attack_btn, opponent_attack, hit_in;
   logic [2:0]       action_state;
   logic             move_active, jump_active, attack_active, block_active, hit_active;
   logic             attack_strike, block_success;
   logic [CNT_W-1:0] frame_cnt;

   player_action_fsm #(
      .CNT_W(CNT_W), .ATK1_LEN(ATK1_LEN), .ATK2_LEN(ATK2_LEN),
      .COMBO_WIN(COMBO_WIN), .HITSTUN_LEN(HITSTUN_LEN), .JUMP_LEN(JUMP_LEN)
   ) dut (
      .clk(clk), .reset(reset),
      .move_btn(move_btn), .jump_btn(jump_btn), .attack_btn(attack_btn),
      .opponent_attack(opponent_attack), .hit_in(hit_in),
      .action_state(action_state),
      .move_active(move_active), .jump_active(jump_active),
      .attack_active(attack_active), .block_active(block_active),
      .hit_active(hit_active),
      .attack_strike(attack_strike), .block_success(block_success),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic last_bs;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: current state, its duration and cycles already spent in it
   int m_st, m_len, m_el;
   bit m_combo, m_prev;

   function automatic bit is_timed(input int s);
      return (s == S_JUMP) || (s == S_A1) || (s == S_A2) || (s == S_HIT);
   endfunction

   function automatic int len_of(input int s);
      case (s)
         S_JUMP:  return JUMP_LEN;
         S_A1:    return ATK1_LEN;
         S_A2:    return ATK2_LEN;
         S_HIT:   return HITSTUN_LEN;
         default: return 1;
      endcase
   endfunction

   function automatic int m_remaining();
      return is_timed(m_st) ? (m_len - 1 - m_el) : 0;
   endfunction

   function automatic void m_enter(input int s);
      m_st    = s;
      m_el    = 0;
      m_len   = len_of(s);
      m_combo = 1'b0;
   endfunction

   function automatic void m_reset();
      m_enter(S_IDLE);
      m_prev = 1'b0;
   endfunction

   function automatic void m_update(input bit mv, input bit jp, input bit at, input bit op, input bit ht);
      bit pressed, last;
      pressed = at && !m_prev;
      m_prev  = at;
      last    = is_timed(m_st) && (m_el == m_len - 1);
      case (m_st)
         S_IDLE:
            if (ht) m_enter(S_HIT);
            else if (pressed) m_enter(S_A1);
            else if (jp) m_enter(S_JUMP);
            else if (mv) m_enter(S_MOVE);
            else if (op) m_enter(S_BLOCK);
         S_MOVE:
            if (ht) m_enter(S_HIT);
            else if (pressed) m_enter(S_A1);
            else if (jp) m_enter(S_JUMP);
            else if (!mv) m_enter(S_IDLE);
         S_BLOCK:
            if (pressed) m_enter(S_A1);
            else if (!op) m_enter(S_IDLE);
         S_A1:
            if (ht) m_enter(S_HIT);
            else begin
               if (pressed && (m_remaining() < COMBO_WIN)) m_combo = 1'b1;
               if (last) m_enter(m_combo ? S_A2 : S_IDLE);
               else m_el++;
            end
         S_HIT:
            if (ht) m_enter(S_HIT);
            else if (last) m_enter(S_IDLE);
            else m_el++;
         default:
            if (ht) m_enter(S_HIT);
            else if (last) m_enter(S_IDLE);
            else m_el++;
      endcase
   endfunction

   function automatic logic [6:0] dut_flags();
      return {move_active, jump_active, attack_active, block_active, hit_active,
              attack_strike, block_success};
   endfunction

   function automatic logic [6:0] exp_flags();
      bit at;
      at = (m_st == S_A1) || (m_st == S_A2);
      return {m_st == S_MOVE, m_st == S_JUMP, at, m_st == S_BLOCK, m_st == S_HIT,
              at && (m_el == 0), (m_st == S_BLOCK) && hit_in};
   endfunction

   task automatic step(input bit mv, input bit jp, input bit at, input bit op, input bit ht);
      @(negedge clk);
      move_btn = mv; jump_btn = jp; attack_btn = at; opponent_attack = op; hit_in = ht;
      #2;
      check_val("state", action_state, m_st);
      check_val("frame_cnt", frame_cnt, m_remaining());
      check_val("flags", dut_flags(), exp_flags());
      last_bs = block_success;
      @(posedge clk);
      m_update(mv, jp, at, op, ht);
      #1;
   endtask

   task automatic do_reset(input bit hold);
      @(negedge clk);
      #2;
      reset = 1'b1;
      move_btn = 0; jump_btn = 0; opponent_attack = 0; hit_in = 0; attack_btn = hold;
      #1;
      check_val("rst_state", action_state, 0);
      check_val("rst_cnt", frame_cnt, 0);
      check_val("rst_flags", dut_flags(), 0);
      @(posedge clk);
      #1;
      check_val("rst_hold_state", action_state, 0);
      check_val("rst_hold_flags", dut_flags(), 0);
      #1;
      reset = 1'b0;
      m_reset();
   endtask

   initial begin
      int cnt_a, cnt_b, strikes;
      bit done;
      reset = 1'b1;
      move_btn = 0; jump_btn = 0; attack_btn = 0; opponent_attack = 0; hit_in = 0;
      last_bs = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_val("init_state", action_state, 0);
      check_val("init_cnt", frame_cnt, 0);
      check_val("init_flags", dut_flags(), 0);
      #1;
      reset = 1'b0;

      // single press held: six ATTACK1 cycles, one strike, no retrigger
      cnt_a = 0; strikes = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0, 0);
         if (i == 0) check_val("a1_entry_cnt", frame_cnt, ATK1_LEN - 1);
         if (action_state == 3'(S_A1)) cnt_a++;
         strikes += int'(attack_strike);
      end
      check_val("a1_cycles", cnt_a, ATK1_LEN);
      check_val("a1_strikes", strikes, 1);
      check_val("held_no_retrigger", action_state, S_IDLE);

      // combo press at frame_cnt 2 -> ATTACK2 for eight cycles
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      check_val("combo_press_cnt", frame_cnt, 2);
      step(0, 0, 1, 0, 0);
      cnt_b = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 0, 0);
         if (action_state == 3'(S_A2)) cnt_b++;
      end
      check_val("a2_cycles", cnt_b, ATK2_LEN);

      // press outside the combo window is discarded
      cnt_a = 0; cnt_b = 0;
      step(0, 0, 1, 0, 0); if (action_state == 3'(S_A1)) cnt_a++;
      step(0, 0, 0, 0, 0); if (action_state == 3'(S_A1)) cnt_a++;
      step(0, 0, 1, 0, 0); if (action_state == 3'(S_A1)) cnt_a++;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0);
         if (action_state == 3'(S_A1)) cnt_a++;
         if (action_state == 3'(S_A2)) cnt_b++;
      end
      check_val("late_press_a1", cnt_a, ATK1_LEN);
      check_val("late_press_no_a2", cnt_b, 0);

      // hit during ATTACK1 cycle 3, re-hit at stun frame 5 -> 15 stun cycles
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      cnt_a = 0; done = 0;
      step(0, 0, 0, 0, 1);
      if (action_state == 3'(S_HIT)) cnt_a++;
      for (int i = 0; i < 25; i++) begin
         bit h;
         h = (m_st == S_HIT) && (m_remaining() == 5) && !done;
         if (h) done = 1;
         step(0, 0, 0, 0, h);
         if (action_state == 3'(S_HIT)) cnt_a++;
      end
      check_val("hit_total", cnt_a, 15);

      // block absorbs hit with one-cycle pulse
      step(0, 0, 0, 1, 0);
      check_val("block_enter", action_state, S_BLOCK);
      step(0, 0, 0, 1, 1);
      check_val("block_success", last_bs, 1);
      check_val("block_no_hit", action_state, S_BLOCK);
      step(0, 0, 0, 1, 0);
      check_val("block_pulse_end", last_bs, 0);
      step(0, 0, 0, 0, 0);
      check_val("block_exit", action_state, S_IDLE);

      // attack wins over jump/move; hit in jump cycle 7
      step(1, 1, 1, 0, 0);
      check_val("atk_priority", action_state, S_A1);
      repeat (8) step(0, 0, 0, 0, 0);
      check_val("back_idle", action_state, S_IDLE);
      step(0, 1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      check_val("jump_c7_cnt", frame_cnt, JUMP_LEN - 7);
      step(0, 0, 0, 0, 1);
      check_val("jump_hit", action_state, S_HIT);
      repeat (12) step(0, 0, 0, 0, 0);

      // reset pulse mid-ATTACK2, then resume from IDLE
      step(0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      check_val("pre_reset_a2", action_state, S_A2);
      do_reset(0);
      step(1, 0, 0, 0, 0);
      check_val("resume_move", action_state, S_MOVE);
      step(0, 0, 0, 0, 0);

      // attack held across reset release counts as a press
      do_reset(1);
      step(0, 0, 1, 0, 0);
      check_val("press_across_reset", action_state, S_A1);
      repeat (8) step(0, 0, 0, 0, 0);

      // random controls with sticky levels
      begin
         bit mv, jp, at, op;
         mv = 0; jp = 0; at = 0; op = 0;
         for (int i = 0; i < 3000; i++) begin
            bit ht;
            if ($urandom_range(0, 399) == 0) do_reset(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0)  mv = ~mv;
            if ($urandom_range(0, 5) == 0)  jp = ~jp;
            if ($urandom_range(0, 2) == 0)  at = ~at;
            if ($urandom_range(0, 15) == 0) op = ~op;
            ht = ($urandom_range(0, 11) == 0);
            step(mv, jp, at, op, ht);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
